// File: rtl/apb_coef_slave_if.sv
// APB slave-side bus bundle for the coefficient register block.
interface apb_coef_slave_if #(
   parameter int ADDR_WIDTH = 10
);
   logic [ADDR_WIDTH-1:0] i_paddr;
   logic                  i_psel;
   logic                  i_penable;
   logic                  i_pwrite;
   logic [31:0]           i_pwdata;
   logic [31:0]           o_prdata;
   logic                  o_pready;
   logic                  o_pslverr;

   modport master (
      output i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
      input  o_prdata, o_pready, o_pslverr
   );

   modport slave (
      input  i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
      output o_prdata, o_pready, o_pslverr
   );
endinterface

// File: rtl/apb_coef_slave.sv
// APB coefficient register bank with wait states; APB_COEF_SHADOW_EN adds a
// pending/active double buffer that swaps on the rising edge of i_vs.
module apb_coef_slave #(
   parameter int ADDR_WIDTH  = 10,
   parameter int NUM_REGS    = 36,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rstn_apb,
   apb_coef_slave_if.slave        apb,
   input  logic                   i_vs,
   output logic [NUM_REGS*32-1:0] o_regs,
   output logic                   o_commit
);
   localparam int             IW        = ADDR_WIDTH - 2;
   localparam logic [IW-1:0]  CTRL_IDX  = IW'(10'h3FC >> 2);
   localparam logic [2:0]     WAIT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RESP} state_t;

   state_t        state, nxt;
   logic [2:0]    wait_cnt;
   logic [IW-1:0] idx;
   logic          is_coef, is_ctrl;
   logic          wr_coef;
   logic [31:0]   rd_val;
   logic [31:0]   coef_regs [NUM_REGS];
   logic          unused_sig;

   assign idx     = apb.i_paddr[ADDR_WIDTH-1:2];
   assign is_coef = 32'(idx) < 32'(NUM_REGS);
   assign is_ctrl = (idx == CTRL_IDX);

   always_ff @(posedge clk or posedge rstn_apb) begin
      if (rstn_apb) state <= S_IDLE;
      else          state <= nxt;
   end

   // A dropped select before the response phase abandons the transfer.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (apb.i_psel && !apb.i_penable) nxt = S_SETUP;
         S_SETUP: if (!apb.i_psel)                  nxt = S_IDLE;
                  else if (apb.i_penable)           nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
         S_WAIT:  if (!apb.i_psel)                  nxt = S_IDLE;
                  else if (wait_cnt == WAIT_LAST)   nxt = S_RESP;
         S_RESP:                                    nxt = S_IDLE;
         default:                                   nxt = S_IDLE;
      endcase
   end

   always_comb begin
      apb.o_pready = (state == S_RESP);
      wr_coef      = (state == S_RESP) && apb.i_pwrite && is_coef;
   end

   always_ff @(posedge clk or posedge rstn_apb) begin
      if (rstn_apb)              wait_cnt <= '0;
      else if (state == S_WAIT)  wait_cnt <= wait_cnt + 3'd1;
      else                       wait_cnt <= '0;
   end

   always_ff @(posedge clk or posedge rstn_apb) begin
      if (rstn_apb) begin
         for (int k = 0; k < NUM_REGS; k++) coef_regs[k] <= '0;
      end else if (wr_coef) begin
         for (int k = 0; k < NUM_REGS; k++)
            if (idx == IW'(k)) coef_regs[k] <= apb.i_pwdata;
      end
   end

   // Read data and error are registered on entry to RESP and held at 0 otherwise.
   always_ff @(posedge clk or posedge rstn_apb) begin
      if (rstn_apb) begin
         apb.o_prdata  <= '0;
         apb.o_pslverr <= 1'b0;
      end else begin
         apb.o_prdata  <= (nxt == S_RESP && !apb.i_pwrite) ? rd_val : 32'd0;
         apb.o_pslverr <= (nxt == S_RESP) && !(is_coef || is_ctrl);
      end
   end

`ifdef APB_COEF_SHADOW_EN
   logic        vs_q, vs_rise, pend_flag, commit_q, wr_ctrl;
   logic [31:0] active_regs [NUM_REGS];

   assign vs_rise    = i_vs & ~vs_q;
   assign wr_ctrl    = (state == S_RESP) && apb.i_pwrite && is_ctrl;
   assign o_commit   = commit_q;
   assign unused_sig = &{1'b0, apb.i_paddr[1:0]};

   always_comb begin
      rd_val = '0;
      if (is_coef) begin
         for (int k = 0; k < NUM_REGS; k++)
            if (idx == IW'(k)) rd_val = coef_regs[k];
      end else if (is_ctrl) begin
         rd_val = {30'b0, pend_flag, 1'b0};
      end
   end

   // A request landing on the same cycle as an edge waits for the next edge.
   always_ff @(posedge clk or posedge rstn_apb) begin
      if (rstn_apb) begin
         vs_q      <= 1'b0;
         pend_flag <= 1'b0;
         commit_q  <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) active_regs[k] <= '0;
      end else begin
         vs_q     <= i_vs;
         commit_q <= vs_rise && pend_flag;
         if (vs_rise && pend_flag)
            for (int k = 0; k < NUM_REGS; k++) active_regs[k] <= coef_regs[k];
         if (wr_ctrl && apb.i_pwdata[0]) pend_flag <= 1'b1;
         else if (vs_rise)               pend_flag <= 1'b0;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign o_regs[32*k +: 32] = active_regs[k];
   end
`else
   assign o_commit   = wr_coef;
   assign unused_sig = &{1'b0, apb.i_paddr[1:0], i_vs};

   always_comb begin
      rd_val = '0;
      if (is_coef)
         for (int k = 0; k < NUM_REGS; k++)
            if (idx == IW'(k)) rd_val = coef_regs[k];
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign o_regs[32*k +: 32] = coef_regs[k];
   end
`endif
endmodule

// File: tb/tb_apb_coef_slave.sv
// Directed bench for apb_coef_slave: vector table plus hand sequences for
// bank commit, select abort and reset during a transfer.
module tb_apb_coef_slave;
   localparam int AW = 10;
   localparam int NR = 36;
   localparam int WC = 1;
`ifdef APB_COEF_SHADOW_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rstn_apb = 1'b1;
   logic              i_vs = 1'b0;
   logic [NR*32-1:0]  o_regs;
   logic              o_commit;

   apb_coef_slave_if #(.ADDR_WIDTH(AW)) bus ();

   apb_coef_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_CYCLES(WC)) dut (
      .clk      (clk),
      .rstn_apb (rstn_apb),
      .apb      (bus),
      .i_vs     (i_vs),
      .o_regs   (o_regs),
      .o_commit (o_commit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        eerr;
      logic        ecm;
   } vec_t;

   vec_t        tbl [12];
   logic [31:0] exp_act [NR];
   int          nchk = 0;
   int          npass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_regs(input string nm);
      for (int k = 0; k < NR; k++)
         chk($sformatf("%s_reg%0d", nm, k), o_regs[32*k +: 32], exp_act[k]);
   endtask

   // Starts in the cycle where the bus is idle, returns in the IDLE cycle after RESP.
   task automatic xfer(input logic [9:0] addr, input logic wr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output logic cm, output int lat);
      rd = '0; err = 1'b0; cm = 1'b0;
      bus.i_paddr = addr; bus.i_pwrite = wr; bus.i_pwdata = wd;
      bus.i_psel = 1'b1; bus.i_penable = 1'b0;
      @(posedge clk); #1; lat = 1;
      bus.i_penable = 1'b1;
      while (!bus.o_pready && lat < 16) begin
         @(posedge clk); #1; lat++;
      end
      rd = bus.o_prdata; err = bus.o_pslverr; cm = o_commit;
      @(posedge clk); #1;
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err, cm;
      int          lat;

      bus.i_paddr = '0; bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      bus.i_pwrite = 1'b0; bus.i_pwdata = '0;
      for (int k = 0; k < NR; k++) exp_act[k] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_pready",  {31'b0, bus.o_pready},  32'd0);
      chk("rst_prdata",  bus.o_prdata,           32'd0);
      chk("rst_pslverr", {31'b0, bus.o_pslverr}, 32'd0);
      chk("rst_commit",  {31'b0, o_commit},      32'd0);
      chk("rst_regs_or", {31'b0, |o_regs},       32'd0);
      rstn_apb = 1'b0;
      @(posedge clk); #1;

      tbl[0]  = '{10'h008, 1'b1, 32'h0000_1234, 32'h0,          1'b0, !SH};
      tbl[1]  = '{10'h008, 1'b0, 32'h0,         32'h0000_1234,  1'b0, 1'b0};
      tbl[2]  = '{10'h00C, 1'b1, 32'h0000_0055, 32'h0,          1'b0, !SH};
      tbl[3]  = '{10'h00E, 1'b0, 32'h0,         32'h0000_0055,  1'b0, 1'b0};
      tbl[4]  = '{10'h08C, 1'b1, 32'hA5A5_A5A5, 32'h0,          1'b0, !SH};
      tbl[5]  = '{10'h08C, 1'b0, 32'h0,         32'hA5A5_A5A5,  1'b0, 1'b0};
      tbl[6]  = '{10'h090, 1'b1, 32'h1111_1111, 32'h0,          1'b1, 1'b0};
      tbl[7]  = '{10'h090, 1'b0, 32'h0,         32'h0,          1'b1, 1'b0};
      tbl[8]  = '{10'h200, 1'b1, 32'hCAFE_F00D, 32'h0,          1'b1, 1'b0};
      tbl[9]  = '{10'h200, 1'b0, 32'h0,         32'h0,          1'b1, 1'b0};
      tbl[10] = '{10'h3FC, 1'b0, 32'h0,         32'h0,          1'b0, 1'b0};
      tbl[11] = '{10'h000, 1'b0, 32'h0,         32'h0,          1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         xfer(tbl[i].addr, tbl[i].wr, tbl[i].wd, rd, err, cm, lat);
         chk($sformatf("v%0d_rdata", i),  rd,             tbl[i].erd);
         chk($sformatf("v%0d_err", i),    {31'b0, err},   {31'b0, tbl[i].eerr});
         chk($sformatf("v%0d_commit", i), {31'b0, cm},    {31'b0, tbl[i].ecm});
         chk($sformatf("v%0d_lat", i),    32'(lat),       32'd3);
         chk($sformatf("v%0d_idle_rdy", i), {31'b0, bus.o_pready}, 32'd0);
         chk($sformatf("v%0d_idle_rd", i),  bus.o_prdata,          32'd0);
      end

      if (!SH) begin
         exp_act[2] = 32'h0000_1234; exp_act[3] = 32'h0000_0055; exp_act[35] = 32'hA5A5_A5A5;
      end
      chk_regs("tbl");

      xfer(10'h3FC, 1'b1, 32'h1, rd, err, cm, lat);
      chk("ctrl_wr_err", {31'b0, err}, 32'd0);
      xfer(10'h3FC, 1'b0, 32'h0, rd, err, cm, lat);
      chk("ctrl_rd_pend", rd, SH ? 32'h2 : 32'h0);
      i_vs = 1'b1;
      chk("vs_commit_pre", {31'b0, o_commit}, 32'd0);
      @(posedge clk); #1;
      chk("vs_commit_pulse", {31'b0, o_commit}, {31'b0, SH});
      if (SH) begin
         exp_act[2] = 32'h0000_1234; exp_act[3] = 32'h0000_0055; exp_act[35] = 32'hA5A5_A5A5;
      end
      chk("vs_reg2", o_regs[95:64], 32'h0000_1234);
      @(posedge clk); #1;
      chk("vs_commit_post", {31'b0, o_commit}, 32'd0);
      i_vs = 1'b0;
      xfer(10'h3FC, 1'b0, 32'h0, rd, err, cm, lat);
      chk("ctrl_rd_clear", rd, 32'h0);
      chk_regs("vs");

      // CTRL write whose RESP cycle coincides with a detected i_vs edge.
      xfer(10'h008, 1'b1, 32'h0000_0077, rd, err, cm, lat);
      if (!SH) exp_act[2] = 32'h0000_0077;
      bus.i_paddr = 10'h3FC; bus.i_pwrite = 1'b1; bus.i_pwdata = 32'h1;
      bus.i_psel = 1'b1; bus.i_penable = 1'b0;
      @(posedge clk); #1; bus.i_penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("coinc_resp_rdy", {31'b0, bus.o_pready}, 32'd1);
      i_vs = 1'b1;
      @(posedge clk); #1;
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      chk("coinc_no_commit", {31'b0, o_commit}, 32'd0);
      chk("coinc_reg2_hold", o_regs[95:64], exp_act[2]);
      i_vs = 1'b0;
      @(posedge clk); #1;
      i_vs = 1'b1;
      @(posedge clk); #1;
      chk("coinc_next_commit", {31'b0, o_commit}, {31'b0, SH});
      exp_act[2] = 32'h0000_0077;
      chk("coinc_reg2_new", o_regs[95:64], exp_act[2]);
      i_vs = 1'b0;
      @(posedge clk); #1;

      // Select dropped while in WAIT.
      bus.i_paddr = 10'h000; bus.i_pwrite = 1'b1; bus.i_pwdata = 32'hDEAD_BEEF;
      bus.i_psel = 1'b1; bus.i_penable = 1'b0;
      @(posedge clk); #1; bus.i_penable = 1'b1;
      @(posedge clk); #1;
      chk("abort_wait_rdy", {31'b0, bus.o_pready}, 32'd0);
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("abort_rdy%0d", c), {31'b0, bus.o_pready}, 32'd0);
         chk($sformatf("abort_cm%0d", c),  {31'b0, o_commit},     32'd0);
      end
      chk("abort_reg0", o_regs[31:0], 32'h0);
      xfer(10'h000, 1'b0, 32'h0, rd, err, cm, lat);
      chk("abort_rd0", rd, 32'h0);
      chk("abort_lat", 32'(lat), 32'd3);

      // Reset asserted in the RESP cycle of a write.
      bus.i_paddr = 10'h004; bus.i_pwrite = 1'b1; bus.i_pwdata = 32'hFFFF_FFFF;
      bus.i_psel = 1'b1; bus.i_penable = 1'b0;
      @(posedge clk); #1; bus.i_penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_resp_rdy", {31'b0, bus.o_pready}, 32'd1);
      rstn_apb = 1'b1;
      #1;
      chk("mid_pready",  {31'b0, bus.o_pready},  32'd0);
      chk("mid_prdata",  bus.o_prdata,           32'd0);
      chk("mid_pslverr", {31'b0, bus.o_pslverr}, 32'd0);
      chk("mid_commit",  {31'b0, o_commit},      32'd0);
      for (int k = 0; k < NR; k++) exp_act[k] = '0;
      chk_regs("mid");
      bus.i_psel = 1'b0; bus.i_penable = 1'b0;
      @(posedge clk); #1;
      rstn_apb = 1'b0;
      @(posedge clk); #1;
      xfer(10'h004, 1'b0, 32'h0, rd, err, cm, lat);
      chk("mid_rd1", rd, 32'h0);
      chk("mid_rd1_lat", 32'(lat), 32'd3);
      chk("mid_reg1", o_regs[63:32], 32'h0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
